// File: rtl/ofs_plat_avalon_mem_slave_ram.sv
// Avalon-MM responder backed by an on-chip RAM: burst reads and writes with
// byteenable, request user echoed on both response channels, registered waitrequest.
//
// state    | meaning
// IDLE     | accepting a read or the SOP beat of a write
// RD_BURST | issuing one RAM read per cycle, waitrequest held high
// WR_BURST | accepting the remaining beats of a write burst
module ofs_plat_avalon_mem_slave_ram #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int USER_WIDTH      = 8,
    parameter int RESPONSE_WIDTH  = 2,
    parameter int READ_LATENCY    = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [ADDR_WIDTH-1:0]       address,
    input  logic                        read,
    input  logic                        write,
    input  logic [BURST_CNT_WIDTH-1:0]  burstcount,
    input  logic [DATA_WIDTH-1:0]       writedata,
    input  logic [DATA_WIDTH/8-1:0]     byteenable,
    input  logic [USER_WIDTH-1:0]       user,
    output logic                        waitrequest,
    output logic                        readdatavalid,
    output logic [DATA_WIDTH-1:0]       readdata,
    output logic [RESPONSE_WIDTH-1:0]   response,
    output logic [USER_WIDTH-1:0]       readresponseuser,
    output logic                        writeresponsevalid,
    output logic [RESPONSE_WIDTH-1:0]   writeresponse,
    output logic [USER_WIDTH-1:0]       writeresponseuser
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RD_BURST = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;

    localparam logic [RESPONSE_WIDTH-1:0]  RESP_OKAY   = '0;
    localparam logic [RESPONSE_WIDTH-1:0]  RESP_SLVERR = RESPONSE_WIDTH'(2);
    localparam logic [BURST_CNT_WIDTH-1:0] MAX_BURST   = BURST_CNT_WIDTH'(1) << (BURST_CNT_WIDTH - 1);
    localparam logic [BURST_CNT_WIDTH-1:0] ONE_BEAT    = BURST_CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [1:0]                 state_q, state_d;
    logic                       waitrequest_q, waitrequest_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [BURST_CNT_WIDTH-1:0] rem_q, rem_d;
    logic [USER_WIDTH-1:0]      user_q, user_d;
    logic                       err_q, err_d;
    logic                       wr_rsp_valid_q, wr_rsp_valid_d;
    logic [RESPONSE_WIDTH-1:0]  wr_rsp_q, wr_rsp_d;
    logic [USER_WIDTH-1:0]      wr_rsp_user_q, wr_rsp_user_d;

    logic                       rd_vld_q  [READ_LATENCY];
    logic                       rd_vld_d  [READ_LATENCY];
    logic [DATA_WIDTH-1:0]      rd_data_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]      rd_data_d [READ_LATENCY];
    logic [RESPONSE_WIDTH-1:0]  rd_resp_q [READ_LATENCY];
    logic [RESPONSE_WIDTH-1:0]  rd_resp_d [READ_LATENCY];
    logic [USER_WIDTH-1:0]      rd_user_q [READ_LATENCY];
    logic [USER_WIDTH-1:0]      rd_user_d [READ_LATENCY];

    logic                       burst_ok;
    logic                       ram_we;
    logic [ADDR_WIDTH-1:0]      ram_waddr;
    logic                       issue;

    assign burst_ok = (burstcount != '0) && (burstcount <= MAX_BURST);

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        rem_d          = rem_q;
        user_d         = user_q;
        err_d          = err_q;
        wr_rsp_valid_d = 1'b0;
        wr_rsp_d       = wr_rsp_q;
        wr_rsp_user_d  = wr_rsp_user_q;
        ram_we         = 1'b0;
        ram_waddr      = addr_q;
        issue          = 1'b0;

        case (state_q)
            IDLE: begin
                // write wins when both are requested; the read is dropped
                if (!waitrequest_q && write) begin
                    if (!burst_ok) begin
                        wr_rsp_valid_d = 1'b1;
                        wr_rsp_d       = RESP_SLVERR;
                        wr_rsp_user_d  = user;
                    end else begin
                        ram_we    = 1'b1;
                        ram_waddr = address;
                        if (burstcount == ONE_BEAT) begin
                            wr_rsp_valid_d = 1'b1;
                            wr_rsp_d       = RESP_OKAY;
                            wr_rsp_user_d  = user;
                        end else begin
                            state_d = WR_BURST;
                            addr_d  = address + ADDR_WIDTH'(1);
                            rem_d   = burstcount - ONE_BEAT;
                            user_d  = user;
                        end
                    end
                end else if (!waitrequest_q && read) begin
                    state_d = RD_BURST;
                    addr_d  = address;
                    user_d  = user;
                    err_d   = !burst_ok;
                    rem_d   = burst_ok ? burstcount : ONE_BEAT;
                end
            end
            RD_BURST: begin
                issue  = 1'b1;
                addr_d = addr_q + ADDR_WIDTH'(1);
                rem_d  = rem_q - ONE_BEAT;
                if (rem_q == ONE_BEAT) begin
                    state_d = IDLE;
                end
            end
            WR_BURST: begin
                if (write) begin
                    ram_we = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - ONE_BEAT;
                    if (rem_q == ONE_BEAT) begin
                        state_d        = IDLE;
                        wr_rsp_valid_d = 1'b1;
                        wr_rsp_d       = RESP_OKAY;
                        wr_rsp_user_d  = user_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        waitrequest_d = (state_d == RD_BURST);
    end

    // Error beats never touch the RAM and return zero data
    always_comb begin
        rd_vld_d[0]  = issue;
        rd_data_d[0] = (issue && !err_q) ? mem[addr_q] : '0;
        rd_resp_d[0] = (issue && err_q) ? RESP_SLVERR : RESP_OKAY;
        rd_user_d[0] = user_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            rd_vld_d[i]  = rd_vld_q[i-1];
            rd_data_d[i] = rd_data_q[i-1];
            rd_resp_d[i] = rd_resp_q[i-1];
            rd_user_d[i] = rd_user_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            waitrequest_q  <= 1'b1;
            addr_q         <= '0;
            rem_q          <= '0;
            user_q         <= '0;
            err_q          <= 1'b0;
            wr_rsp_valid_q <= 1'b0;
            wr_rsp_q       <= '0;
            wr_rsp_user_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_vld_q[i]  <= 1'b0;
                rd_data_q[i] <= '0;
                rd_resp_q[i] <= '0;
                rd_user_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            waitrequest_q  <= waitrequest_d;
            addr_q         <= addr_d;
            rem_q          <= rem_d;
            user_q         <= user_d;
            err_q          <= err_d;
            wr_rsp_valid_q <= wr_rsp_valid_d;
            wr_rsp_q       <= wr_rsp_d;
            wr_rsp_user_q  <= wr_rsp_user_d;
            rd_vld_q       <= rd_vld_d;
            rd_data_q      <= rd_data_d;
            rd_resp_q      <= rd_resp_d;
            rd_user_q      <= rd_user_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (byteenable[b]) begin
                    mem[ram_waddr][b*8 +: 8] <= writedata[b*8 +: 8];
                end
            end
        end
    end

    assign waitrequest        = waitrequest_q;
    assign readdatavalid      = rd_vld_q[READ_LATENCY-1];
    assign readdata           = rd_data_q[READ_LATENCY-1];
    assign response           = rd_resp_q[READ_LATENCY-1];
    assign readresponseuser   = rd_user_q[READ_LATENCY-1];
    assign writeresponsevalid = wr_rsp_valid_q;
    assign writeresponse      = wr_rsp_q;
    assign writeresponseuser  = wr_rsp_user_q;

    a_no_rd_wr_in_idle: assert property (@(posedge clk) disable iff (!reset_n)
        !(state_q == IDLE && !waitrequest_q && read && write))
        else $fatal(1, "read and write requested together in IDLE");

    a_no_rd_in_wr_burst: assert property (@(posedge clk) disable iff (!reset_n)
        !(state_q == WR_BURST && read))
        else $fatal(1, "read requested during a write burst");

endmodule
